ks16_seq_mul: RTL and testbench
===============================

Name: ks16_seq_mul

Overview:
- Multi-cycle GF(2)[x] (carry-less) polynomial multiplier built around one shared ks16 Karatsuba core.
- Splits two (16*LIMBS)-bit operands into 16-bit limbs and feeds one limb pair per cycle to the core.
- XOR-accumulates each 31-bit partial product at the correct offset.
- Returns the full (32*LIMBS-1)-bit product over a valid/ready handshake.
- Sits between operand producers (Toom-K evaluation stage or host wrapper) and downstream consumers; it is the only user of its ks16 instance.

Parameters:
LIMBS, 4, number of 16-bit limbs per operand; operand width W=16*LIMBS; legal range 1..16.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand pair a/b valid
in_ready  output  1  block can accept operands (high only in IDLE)
a  input  16*LIMBS  operand A, bit k = coefficient of x^k
b  input  16*LIMBS  operand B, same encoding
out_valid  output  1  product d valid
out_ready  input  1  consumer accepts d
d  output  32*LIMBS-1  product A*B over GF(2), bit k = coefficient of x^k
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst high at a clock edge), next cycle:
  - state=IDLE; i=j=0; operand regs=0; acc=0.
  - in_ready=1, out_valid=0, busy=0, d=0.
  - Reset has priority over every other event, including mid-RUN and in DONE; the in-flight operation is discarded without any output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a and b into operand regs, clear acc, set i=j=0, go to RUN.
  - Otherwise stay in IDLE.
- RUN (in_ready=0, busy=1):
  - Each cycle, ks16 is driven combinationally with A limb i (a_r[16i+15:16i]) and B limb j.
  - The 31-bit result p is XORed into acc bits [16(i+j)+30 : 16(i+j)].
  - Counter order: j increments; when j=LIMBS-1, j wraps to 0 and i increments.
  - After the cycle processing i=j=LIMBS-1, go to DONE.
  - RUN lasts exactly LIMBS^2 cycles.
- DONE:
  - out_valid=1, d=acc, in_ready=0.
  - d and out_valid are held stable while out_ready=0, with no timeout.
  - On out_ready: go to IDLE next cycle; d keeps its last value, out_valid drops to 0.
- Latency:
  - Accept edge at cycle T; out_valid first high at T+LIMBS^2+1 (T+17 for LIMBS=4).
  - Throughput: one product per LIMBS^2+2 cycles minimum.
  - No same-cycle accept in DONE: in_ready rises the cycle after the handshake.
- Width rules:
  - acc is 32*LIMBS-1 bits. The highest partial product lands at offset 16*(2*LIMBS-2), top bit 32*LIMBS-2, so nothing is truncated.
  - All accumulation is XOR; there are no carries.
- Boundary conditions:
  - LIMBS=1: exactly 1 RUN cycle, d equals the ks16 result.
  - in_valid asserted during RUN/DONE is ignored and not queued.
  - a/b changing after accept has no effect.
  - out_ready asserted outside DONE is ignored.
  - i/j counters are clog2(LIMBS)+1 bits wide and never exceed LIMBS-1 while in RUN.

Test Plan:
- LIMBS=4, a=1, b=1: accept at T -> out_valid first at T+17, d=1, busy high T+1..T+17, in_ready high at T+18 after out_ready=1 at T+17.
- a=0x3, b=0x3 -> d=0x5 (carry-less, (x+1)^2=x^2+1); a=all ones (64 bits), b=1 -> d=0x0000..FFFFFFFFFFFFFFFF.
- a=1<<63, b=1<<63 -> d has only bit 126 set; a=1<<15, b=1<<16 -> only bit 31 set (cross-limb offset check).
- Backpressure: out_ready=0 for 10 cycles in DONE -> d and out_valid stable, in_ready=0, in_valid pulses ignored; then out_ready=1 -> IDLE next cycle.
- Reset mid-RUN (rst high 5 cycles after accept) -> next cycle state IDLE, in_ready=1, out_valid=0, d=0; next operation a=0xABCD, b=0x1234 gives the correct clmul result.
- 1000 random a/b back-to-back with random out_ready stalls, LIMBS in {1,2,4} -> every d matches the bit-serial clmul model, and each result appears exactly once.

Source files
------------

// File: rtl/ks16_seq_mul.sv
// Sequential carry-less (GF(2)[x]) multiplier: one 16x16 Karatsuba core is reused
// over all LIMBS^2 limb pairs, XOR-accumulating each partial product at its offset.

module ks16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [30:0] o_p
);
  logic [14:0] w_z0, w_z1, w_z2, w_zm;

  function automatic logic [14:0] clmul8(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (y[k]) r = r ^ ({7'd0, x} << k);
    end
    return r;
  endfunction

  // One level of Karatsuba: three 8x8 products instead of four.
  assign w_z0 = clmul8(i_a[7:0], i_b[7:0]);
  assign w_z2 = clmul8(i_a[15:8], i_b[15:8]);
  assign w_zm = clmul8(i_a[7:0] ^ i_a[15:8], i_b[7:0] ^ i_b[15:8]);
  assign w_z1 = w_zm ^ w_z0 ^ w_z2;
  assign o_p  = {w_z2, 16'd0} ^ {8'd0, w_z1, 8'd0} ^ {16'd0, w_z0};
endmodule

module ks16_seq_mul #(
  parameter int LIMBS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LIMBS-1:0]   a,
  input  logic [16*LIMBS-1:0]   b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*LIMBS-2:0]   d,
  output logic                  busy,
  output logic [1:0]            dbg_state
);
  localparam int W  = 16 * LIMBS;
  localparam int AW = 32 * LIMBS - 1;
  localparam int CW = $clog2(LIMBS) + 1;
  localparam logic [CW-1:0] LAST = CW'(LIMBS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [W-1:0]    r_a, r_b;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_i, r_j;

  logic [15:0]     w_la, w_lb;
  logic [30:0]     w_p;
  logic [CW:0]     w_ij;
  logic [AW-1:0]   w_pp, w_acc_nx;

  assign w_la = r_a[16*r_i +: 16];
  assign w_lb = r_b[16*r_j +: 16];

  ks16 u_core (
    .i_a (w_la),
    .i_b (w_lb),
    .o_p (w_p)
  );

  // Partial product for limb pair (i,j) lands at bit 16*(i+j).
  assign w_ij      = {1'b0, r_i} + {1'b0, r_j};
  assign w_pp      = AW'(w_p) << {w_ij, 4'b0000};
  assign w_acc_nx  = r_acc ^ w_pp;
  assign dbg_state = r_state;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid is never withdrawn and its payload never changes until it transfers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_acc     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      d         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_a      <= a;
            r_b      <= b;
            r_acc    <= '0;
            r_i      <= '0;
            r_j      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_acc_nx;
          if (r_j == LAST) begin
            r_j <= '0;
            if (r_i == LAST) begin
              d         <= w_acc_nx;
              out_valid <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_i <= r_i + 1'b1;
            end
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ks16_seq_mul.sv
// Bench for ks16_seq_mul: directed latency/boundary steps on LIMBS=4, then random
// back-to-back traffic with stalls on LIMBS=1, 2 and 4 against a bit-serial model.

module tb_ks16_seq_mul;
  logic clk, rst;
  logic iv1, iv2, iv4, or1, or2, or4;
  logic ir1, ir2, ir4, ov1, ov2, ov4, by1, by2, by4;
  logic [15:0]  a1, b1;
  logic [31:0]  a2, b2;
  logic [63:0]  a4, b4;
  logic [30:0]  d1;
  logic [62:0]  d2;
  logic [126:0] d4;
  logic [1:0]   st1, st2, st4;

  int n_checks = 0;
  int n_fail   = 0;
  logic [126:0] exp_q[$];

  logic         g_ir, g_ov, g_by;
  logic [126:0] g_d;
  logic [1:0]   g_st;

  ks16_seq_mul #(.LIMBS(1)) dut1 (.clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
    .out_valid(ov1), .out_ready(or1), .d(d1), .busy(by1), .dbg_state(st1));
  ks16_seq_mul #(.LIMBS(2)) dut2 (.clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .d(d2), .busy(by2), .dbg_state(st2));
  ks16_seq_mul #(.LIMBS(4)) dut4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .d(d4), .busy(by4), .dbg_state(st4));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [126:0] clmul(input logic [63:0] x, input logic [63:0] y);
    logic [126:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (y[i]) r = r ^ (127'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [63:0] op_mask(input int k);
    int l;
    l = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    return (64'd1 << (16 * l)) - 64'd1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input int k, input logic v, input logic [63:0] av, input logic [63:0] bv);
    case (k)
      0:       begin iv1 = v; a1 = av[15:0]; b1 = bv[15:0]; end
      1:       begin iv2 = v; a2 = av[31:0]; b2 = bv[31:0]; end
      default: begin iv4 = v; a4 = av;       b4 = bv;       end
    endcase
  endtask

  task automatic set_or(input int k, input logic r);
    case (k)
      0:       or1 = r;
      1:       or2 = r;
      default: or4 = r;
    endcase
  endtask

  task automatic sample(input int k);
    case (k)
      0:       begin g_ir = ir1; g_ov = ov1; g_by = by1; g_d = 127'(d1); g_st = st1; end
      1:       begin g_ir = ir2; g_ov = ov2; g_by = by2; g_d = 127'(d2); g_st = st2; end
      default: begin g_ir = ir4; g_ov = ov4; g_by = by4; g_d = d4;       g_st = st4; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [126:0] obs, input logic [126:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair; returns at the first falling edge after the accept edge.
  task automatic do_accept(input int k, input logic [63:0] av, input logic [63:0] bv);
    int t;
    t = 0;
    sample(k);
    while (!g_ir && t < 100) begin
      @(negedge clk); t++; sample(k);
    end
    chk("accept_ready", g_ir, 1);
    set_in(k, 1'b1, av, bv);
    exp_q.push_back(clmul(av & op_mask(k), bv & op_mask(k)));
    @(negedge clk);
    set_in(k, 1'b0, ~av, ~bv);
  endtask

  task automatic wait_done(input int k);
    int t;
    t = 0;
    sample(k);
    while (!g_ov && t < 400) begin
      @(negedge clk); t++; sample(k);
    end
    chk("done_timeout", g_ov, 1);
  endtask

  // Full directed operation; result left in g_d for extra constant checks.
  task automatic single_op(input int k, input logic [63:0] av, input logic [63:0] bv, input string tag);
    logic [126:0] e;
    logic [126:0] dd;
    do_accept(k, av, bv);
    wait_done(k);
    e = exp_q.pop_front();
    dd = g_d;
    chk(tag, dd, e);
    set_or(k, 1'b1);
    @(negedge clk);
    sample(k);
    chk({tag, "_ov_drop"}, g_ov, 0);
    chk({tag, "_ready_back"}, g_ir, 1);
    set_or(k, 1'b0);
    g_d = dd;
  endtask

  // One random operation with random stalls and ignored in_valid/out_ready noise.
  task automatic random_op(input int k);
    logic [63:0] av, bv;
    logic [126:0] e;
    logic r;
    av = {$urandom, $urandom} & op_mask(k);
    bv = {$urandom, $urandom} & op_mask(k);
    do_accept(k, av, bv);
    for (int t = 0; t < 400; t++) begin
      sample(k);
      if (g_ov) begin
        set_in(k, 1'b0, '0, '0);
        r = ($urandom_range(0, 2) != 0);
        set_or(k, r);
        if (r) begin
          e = exp_q.pop_front();
          chk("rand_d", g_d, e);
          @(negedge clk);
          sample(k);
          chk("rand_once", g_ov, 0);
          set_or(k, 1'b0);
          return;
        end
      end else begin
        set_or(k, 1'($urandom_range(0, 1)));
        set_in(k, 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
      end
      @(negedge clk);
    end
    chk("rand_timeout", g_ov, 1);
    set_or(k, 1'b0);
    set_in(k, 1'b0, '0, '0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [126:0] e;
    logic [63:0]  ra, rb;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_in(k, 1'b0, '0, '0);
      set_or(k, 1'b0);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sample(k);
      chk("rst_in_ready", g_ir, 1);
      chk("rst_out_valid", g_ov, 0);
      chk("rst_busy", g_by, 0);
      chk("rst_d", g_d, 0);
      chk("rst_state", g_st, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Latency profile: busy T+1..T+17, out_valid first at T+17, in_ready back at T+18.
    do_accept(2, 64'd1, 64'd1);
    for (int n = 1; n <= 16; n++) begin
      sample(2);
      chk("lat_ov_low", g_ov, 0);
      chk("lat_busy", g_by, 1);
      chk("lat_in_ready_low", g_ir, 0);
      @(negedge clk);
    end
    sample(2);
    chk("lat_ov_t17", g_ov, 1);
    chk("lat_busy_t17", g_by, 1);
    chk("lat_d", g_d, 127'd1);
    e = exp_q.pop_front();
    set_or(2, 1'b1);
    @(negedge clk);
    sample(2);
    chk("lat_in_ready_t18", g_ir, 1);
    chk("lat_ov_t18", g_ov, 0);
    chk("lat_busy_t18", g_by, 0);
    chk("lat_d_held", g_d, e);
    set_or(2, 1'b0);

    single_op(2, 64'h3, 64'h3, "sq_x1");
    chk("sq_x1_const", g_d, 127'h5);
    single_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, "ones_x1");
    chk("ones_x1_const", g_d, 127'h0000_FFFF_FFFF_FFFF_FFFF);
    single_op(2, 64'd1 << 63, 64'd1 << 63, "top_bit");
    chk("top_bit_const", g_d, 127'd1 << 126);
    single_op(2, 64'd1 << 15, 64'd1 << 16, "cross_limb");
    chk("cross_limb_const", g_d, 127'd1 << 31);
    single_op(0, 64'hFFFF, 64'hFFFF, "l1_ones");
    single_op(1, 64'h8000_0001, 64'hC000_0003, "l2_edges");

    // Backpressure in DONE: outputs hold, in_valid pulses ignored and not queued.
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    do_accept(2, ra, rb);
    wait_done(2);
    e = exp_q.pop_front();
    for (int n = 0; n < 10; n++) begin
      set_in(2, 1'(n % 2), {$urandom, $urandom}, {$urandom, $urandom});
      @(negedge clk);
      sample(2);
      chk("bp_ov", g_ov, 1);
      chk("bp_d", g_d, e);
      chk("bp_in_ready", g_ir, 0);
    end
    set_in(2, 1'b0, '0, '0);
    set_or(2, 1'b1);
    @(negedge clk);
    sample(2);
    chk("bp_release_ready", g_ir, 1);
    chk("bp_release_ov", g_ov, 0);
    set_or(2, 1'b0);
    @(negedge clk);
    sample(2);
    chk("bp_not_queued", g_by, 0);

    // Reset mid-RUN discards the operation.
    do_accept(2, {$urandom, $urandom}, {$urandom, $urandom});
    void'(exp_q.pop_back());
    repeat (4) @(negedge clk);
    sample(2);
    chk("mid_run_state", g_st, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sample(2);
    chk("mrst_in_ready", g_ir, 1);
    chk("mrst_ov", g_ov, 0);
    chk("mrst_d", g_d, 0);
    chk("mrst_busy", g_by, 0);
    single_op(2, 64'hABCD, 64'h1234, "post_rst");

    // Random back-to-back traffic.
    for (int n = 0; n < 400; n++) random_op(0);
    for (int n = 0; n < 300; n++) random_op(1);
    for (int n = 0; n < 300; n++) random_op(2);

    chk("queue_empty", 127'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
